// File: rtl/lives_gameover_ctrl.sv
// Lives / invulnerability / game-over sequencer on the 16 Hz LED tick; drives the game-over animator enable.
// Optional extra-life input handshake enabled by defining LIVES_GAMEOVER_EXTRA_LIFE_EN.
module lives_gameover_ctrl #(
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned LIVES_MAX      = 7,
    parameter int unsigned LIVES_W        = 3,
    parameter int unsigned GRACE_TICKS    = 32,
    parameter int unsigned GAMEOVER_TICKS = 80
) (
    input  logic               led_out_clock,
    input  logic               reset,
    input  logic               hit_req,
    input  logic               start_btn,
`ifdef LIVES_GAMEOVER_EXTRA_LIFE_EN
    input  logic               bonus_req,
    output logic               bonus_ack,
`endif
    output logic               hit_ack,
    output logic [LIVES_W-1:0] lives,
    output logic               invuln,
    output logic               gameover,
    output logic               restart
);

    localparam int unsigned CNT_MAX = (GRACE_TICKS > GAMEOVER_TICKS) ? GRACE_TICKS : GAMEOVER_TICKS;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_PLAY       = 2'd0,
        ST_INVULN     = 2'd1,
        ST_GAMEOVER   = 2'd2,
        ST_WAIT_START = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [LIVES_W-1:0] lives_d;
    logic               invuln_d;
    logic               gameover_d;
    logic               restart_d;
    logic               hit_ack_prev;
    logic               start_prev;
    logic               hit_evt;
    logic               bonus_evt;
    logic               start_press;
    logic [LIVES_W-1:0] lives_inc;

    // One event per request: only the rising edge of the registered ack counts.
    assign hit_evt     = hit_ack & ~hit_ack_prev;
    assign start_press = start_btn & ~start_prev;
    assign lives_inc   = (lives >= LIVES_W'(LIVES_MAX)) ? lives : lives + LIVES_W'(1);

`ifdef LIVES_GAMEOVER_EXTRA_LIFE_EN
    logic bonus_ack_prev;

    assign bonus_evt = bonus_ack & ~bonus_ack_prev;

    // Extra-life handshake registers
    always_ff @(posedge led_out_clock) begin
        if (reset) begin
            bonus_ack      <= 1'b0;
            bonus_ack_prev <= 1'b0;
        end else begin
            bonus_ack      <= bonus_req;
            bonus_ack_prev <= bonus_ack;
        end
    end
`else
    assign bonus_evt = 1'b0;
`endif

    // State, counters and registered outputs
    always_ff @(posedge led_out_clock) begin
        if (reset) begin
            state_q      <= ST_PLAY;
            cnt_q        <= '0;
            lives        <= LIVES_W'(LIVES_INIT);
            hit_ack      <= 1'b0;
            hit_ack_prev <= 1'b0;
            start_prev   <= 1'b0;
            invuln       <= 1'b0;
            gameover     <= 1'b0;
            restart      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lives        <= lives_d;
            hit_ack      <= hit_req;
            hit_ack_prev <= hit_ack;
            start_prev   <= start_btn;
            invuln       <= invuln_d;
            gameover     <= gameover_d;
            restart      <= restart_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lives_d    = lives;
        restart_d  = 1'b0;
        invuln_d   = 1'b0;
        gameover_d = 1'b0;

        case (state_q)
            ST_PLAY: begin
                if (hit_evt) begin
                    if (bonus_evt) begin
                        // Simultaneous bonus cancels the loss but the hit still grants grace.
                        state_d = ST_INVULN;
                        cnt_d   = CNT_W'(GRACE_TICKS - 1);
                    end else if (lives > LIVES_W'(1)) begin
                        lives_d = lives - LIVES_W'(1);
                        state_d = ST_INVULN;
                        cnt_d   = CNT_W'(GRACE_TICKS - 1);
                    end else begin
                        lives_d = '0;
                        state_d = ST_GAMEOVER;
                        cnt_d   = CNT_W'(GAMEOVER_TICKS - 1);
                    end
                end else if (bonus_evt) begin
                    lives_d = lives_inc;
                end
            end
            ST_INVULN: begin
                if (bonus_evt) begin
                    lives_d = lives_inc;
                end
                if (cnt_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAMEOVER: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT_START;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT_START: begin
                // A press edge is required so a button held through game-over cannot restart.
                if (start_press) begin
                    state_d   = ST_PLAY;
                    lives_d   = LIVES_W'(LIVES_INIT);
                    restart_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase

        invuln_d   = (state_d == ST_INVULN);
        gameover_d = (state_d == ST_GAMEOVER) || (state_d == ST_WAIT_START);
    end

endmodule
